// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO between the UART receiver and the bus; reports level/overflow.
// Optional idle-timeout flag enabled by defining UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ALMOST_FULL    = 12,
  parameter int unsigned TIMEOUT_CYCLES = 800
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_wr_data,
  input  logic                     i_wr_valid,
  output logic [7:0]               o_rd_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_almost_full,
  output logic                     o_overflow,
  input  logic                     i_clr_overflow,
  output logic                     o_timeout
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = PW - 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if ((ALMOST_FULL < 1) || (ALMOST_FULL > DEPTH)) begin : g_bad_almost_full
    $error("uart_rx_fifo: ALMOST_FULL must be in 1..DEPTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_rx_fifo: TIMEOUT_CYCLES must be at least 1");
  end

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_count;
  logic [PW-1:0] w_count_d;
  logic          r_rd_valid;
  logic          r_empty;
  logic          r_full;
  logic          r_almost_full;
  logic          r_overflow;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_drop;

  assign w_pop   = r_rd_valid & i_rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_wr_en = i_wr_valid & (~r_full | w_pop);
  assign w_drop  = i_wr_valid & r_full & ~w_pop;

  always_comb begin
    w_count_d = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_d = r_count + PW'(1);
      2'b01:   w_count_d = r_count - PW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rd_valid    <= 1'b0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count       <= w_count_d;
      r_rd_valid    <= (w_count_d != '0);
      r_empty       <= (w_count_d == '0);
      r_full        <= (w_count_d == PW'(DEPTH));
      r_almost_full <= (w_count_d >= PW'(ALMOST_FULL));
      // Set has priority over clear.
      r_overflow    <= w_drop | (r_overflow & ~i_clr_overflow);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  // Gate stale memory so the byte output reads zero while empty.
  assign o_rd_data     = r_rd_valid ? r_mem[r_rd_ptr[AW-1:0]] : 8'h00;
  assign o_rd_valid    = r_rd_valid;
  assign o_count       = r_count;
  assign o_empty       = r_empty;
  assign o_full        = r_full;
  assign o_almost_full = r_almost_full;
  assign o_overflow    = r_overflow;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IW-1:0] r_idle;
  logic [IW-1:0] w_idle_d;
  logic          r_timeout;
  logic          w_timeout_d;

  // Any FIFO activity or an empty FIFO restarts the idle count.
  always_comb begin
    w_idle_d = r_idle;
    if (w_wr_en || w_pop || (w_count_d == '0)) begin
      w_idle_d = '0;
    end else if (r_idle != IW'(TIMEOUT_CYCLES)) begin
      w_idle_d = r_idle + IW'(1);
    end
    w_timeout_d = (w_idle_d == IW'(TIMEOUT_CYCLES)) && (w_count_d != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_idle    <= w_idle_d;
      r_timeout <= w_timeout_d;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, ALMOST_FULL=12, TIMEOUT_CYCLES=8).
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic       clr_overflow;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(
    .DEPTH          (16),
    .ALMOST_FULL    (12),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_wr_data      (wr_data),
    .i_wr_valid     (wr_valid),
    .o_rd_data      (rd_data),
    .o_rd_valid     (rd_valid),
    .i_rd_ready     (rd_ready),
    .o_count        (count),
    .o_empty        (empty),
    .o_full         (full),
    .o_almost_full  (almost_full),
    .o_overflow     (overflow),
    .i_clr_overflow (clr_overflow),
    .o_timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic wv, input logic [7:0] wd, input logic rr, input logic clr);
    wr_valid     = wv;
    wr_data      = wd;
    rd_ready     = rr;
    clr_overflow = clr;
    @(posedge clk);
    #1;
    wr_valid     = 1'b0;
    wr_data      = 8'h00;
    rd_ready     = 1'b0;
    clr_overflow = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    wr_data      = 8'h00;
    wr_valid     = 1'b0;
    rd_ready     = 1'b0;
    clr_overflow = 1'b0;
    #12;
    chk("rst_count",    32'(count),       32'd0);
    chk("rst_valid",    32'(rd_valid),    32'd0);
    chk("rst_empty",    32'(empty),       32'd1);
    chk("rst_full",     32'(full),        32'd0);
    chk("rst_afull",    32'(almost_full), 32'd0);
    chk("rst_ovf",      32'(overflow),    32'd0);
    chk("rst_timeout",  32'(timeout),     32'd0);
    chk("rst_rd_data",  32'(rd_data),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Ready while empty must not underflow.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_pop_count", 32'(count), 32'd0);
    chk("empty_pop_empty", 32'(empty), 32'd1);

    // Single byte, one-cycle fall-through latency.
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_valid", 32'(rd_valid), 32'd1);
    chk("a5_data",  32'(rd_data),  32'hA5);
    chk("a5_count", 32'(count),    32'd1);
    chk("a5_empty", 32'(empty),    32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("a5_pop_count", 32'(count),   32'd0);
    chk("a5_pop_data",  32'(rd_data), 32'd0);

    // Fill with 0x01..0x10 from pointer offset 1 so the drain crosses the wrap.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_count", 32'(count),       32'(i));
      chk("fill_afull", 32'(almost_full), 32'(i >= 12));
      chk("fill_full",  32'(full),        32'(i == 16));
    end
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", 32'(rd_data), 32'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(empty),    32'd1);
    chk("drain_count", 32'(count),    32'd0);
    chk("drain_valid", 32'(rd_valid), 32'd0);

    // Overflow: drop on full, clear, and set-wins-over-clear.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_set",   32'(overflow), 32'd1);
    chk("ovf_count", 32'(count),    32'd16);
    chk("ovf_head",  32'(rd_data),  32'h01);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr",   32'(overflow), 32'd0);
    cyc(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr2",  32'(overflow), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      chk("ovf_drain", 32'(rd_data), 32'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("ovf_drain_empty", 32'(empty), 32'd1);

    // Full + write + pop in the same cycle is accepted without overflow.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("wp_count", 32'(count),    32'd16);
    chk("wp_ovf",   32'(overflow), 32'd0);
    chk("wp_full",  32'(full),     32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("wp_drain", 32'(rd_data), (i < 15) ? 32'(8'h22 + 8'(i)) : 32'h77);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("wp_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-stream.
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h12, 1'b0, 1'b0);
    cyc(1'b1, 8'h13, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count),    32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_empty", 32'(empty),    32'd1);
    chk("mid_rst_data",  32'(rd_data),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("post_rst_data",  32'(rd_data), 32'h5A);
    chk("post_rst_count", 32'(count),   32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_empty", 32'(empty),   32'd1);

    // Idle timeout.
    cyc(1'b1, 8'h42, 1'b0, 1'b0);
    chk("to_after_write", 32'(timeout), 32'd0);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("to_idle", 32'(timeout), 32'(k == 8));
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("to_after_pop", 32'(timeout), 32'd0);
`else
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("to_disabled", 32'(timeout), 32'd0);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
`endif
    chk("to_final_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each single-cycle data-valid pulse and byte from the receiver into a first-word-fall-through FIFO, so no byte is lost while the processor or bus is busy. It presents bytes to the consumer through a valid/ready handshake and reports level, almost-full and a sticky overflow status for the UART status register.

Parameters:
DEPTH, 16, number of byte entries; must be a power of 2 and at least 2
ALMOST_FULL, 12, o_almost_full asserts when count >= this value; range 1..DEPTH
TIMEOUT_CYCLES, 800, idle cycles before o_timeout asserts (used only with the optional feature)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous, active-low reset
i_wr_data  in  8  byte from the receiver's data output
i_wr_valid  in  1  single-cycle pulse from the receiver's data-valid output; write request
o_rd_data  out  8  head-of-FIFO byte; meaningful only while o_rd_valid=1
o_rd_valid  out  1  FIFO non-empty
i_rd_ready  in  1  consumer accepts the head byte; a pop occurs when o_rd_valid & i_rd_ready
o_count  out  $clog2(DEPTH)+1  number of stored bytes, 0..DEPTH
o_empty  out  1  count==0
o_full  out  1  count==DEPTH
o_almost_full  out  1  count>=ALMOST_FULL
o_overflow  out  1  sticky; a byte was dropped
i_clr_overflow  in  1  synchronous clear of o_overflow
o_timeout  out  1  idle-timeout flag; tied 0 without the optional feature

Behaviour:
- Reset (asynchronous assert, synchronous-safe release): pointers=0, count=0, o_rd_valid=0, o_empty=1, o_full=0, o_almost_full=0, o_overflow=0, o_timeout=0, o_rd_data=0. Memory contents are not reset.
- Storage: DEPTH x 8 register array. Read and write pointers are $clog2(DEPTH)+1 bits wide, with the extra bit used for wrap. Pointers wrap modulo DEPTH naturally through power-of-2 arithmetic.
- Write: when i_wr_valid=1 and the FIFO is not full (or a pop happens in the same cycle), mem[wr_ptr] is written and wr_ptr increments on the next edge.
- Latency: a byte written at edge N gives o_rd_valid=1 with o_rd_data equal to that byte after edge N, i.e. one cycle. o_rd_data is read combinationally from mem[rd_ptr] (first-word fall-through).
- Pop: when o_rd_valid & i_rd_ready, rd_ptr increments. The next byte, if any, is presented in the following cycle. i_rd_ready while empty has no effect.
- Count: write only gives +1; pop only gives -1; both or neither leaves it unchanged. o_empty, o_full and o_almost_full are all derived from count and registered together with it.
- Full + write with no pop: the byte is dropped, o_overflow is set on that edge, and the stored contents and pointers are unchanged.
- Full + write + pop in the same cycle: the write is accepted, count stays DEPTH, and there is no overflow.
- Empty + write: the pop path is inactive that cycle because o_rd_valid=0.
- Overflow clear: i_clr_overflow=1 clears o_overflow on the next edge. If a new overflow occurs in the same cycle, set wins and o_overflow stays 1.
- Reset mid-operation discards all contents immediately, and the outputs take their reset values asynchronously.
- There is no internal state machine beyond the pointer/count datapath; all outputs are registered, except o_rd_data, which comes through a mux from registers.

Optional Feature:
Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined: an idle counter of $clog2(TIMEOUT_CYCLES+1) bits.
  - The counter resets to 0 on any accepted write, and whenever the FIFO is empty; otherwise it increments, saturating at TIMEOUT_CYCLES.
  - o_timeout=1 while the counter equals TIMEOUT_CYCLES and the FIFO is non-empty.
  - o_timeout clears on the next edge after any pop or accepted write.
  - Purpose: lets software drain partial messages.
- Undefined: the counter logic is absent and o_timeout is a constant 0.

Test Plan:
- Reset then write 0xA5 pulse with i_rd_ready=0 -> next cycle o_rd_valid=1, o_rd_data=0xA5, o_count=1, o_empty=0.
- Write 0x01..0x10 (16 bytes), then pop all with i_rd_ready=1 -> o_full=1 after the 16th write, o_almost_full=1 from the 12th; bytes read back in order 0x01..0x10 across the pointer wrap, and o_empty=1 at the end.
- Fill 16, write 0xEE with no pop -> o_overflow=1, o_count=16, head still 0x01; pulse i_clr_overflow -> o_overflow=0.
- Fill 16, then write 0x77 and pop in the same cycle -> o_count=16, o_overflow=0, and 0x77 is the last byte read out.
- Write 3 bytes, assert i_rst_n=0 mid-stream for 1 cycle -> o_count=0, o_rd_valid=0 immediately; the next write of 0x5A reads back as 0x5A.
- With UART_RX_FIFO_TIMEOUT_EN and TIMEOUT_CYCLES=8: write 1 byte, idle -> o_timeout=1 exactly 8 cycles after the write; pop -> o_timeout=0 next cycle. Without the macro, o_timeout stays 0.
